ponylink_m2s_arbiter: RTL and testbench
=======================================

// Module: ponylink_m2s_arbiter
// PURPOSE
//  - Packet-granular arbiter that shares the single M2S AXI-stream input of ponylink_master between NUM_CH requesters.
//  - Whole packets only: a grant is held from the first beat through the beat with tlast, so packets never interleave on the link.
//  - Tags every beat with the source channel index on out_tuser, which feeds master in_tuser (M2S_TUSER_WIDTH = CH_BITS).
//  - The slave side demuxes on tuser.
// PARAMETERS
//  - NUM_CH       4  number of requester channels, 2..16
//  - TDATA_WIDTH  8  data width per channel and on the output
//  - CH_BITS      2  width of the channel tag; must equal clog2(NUM_CH)
// PORTS
//  - clk           in   1                clock, all logic on posedge
//  - reset         in   1                synchronous, active-high reset
//  - linkready     in   1                from ponylink_master; low blocks new grants
//  - ch_tdata      in   NUM_CH*TDATA_W   per-channel data, ch i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//  - ch_tvalid     in   NUM_CH           per-channel valid
//  - ch_tlast      in   NUM_CH           per-channel end of packet
//  - ch_tready     out  NUM_CH           per-channel ready, one-hot or zero
//  - out_tdata     out  TDATA_WIDTH      to master in_tdata
//  - out_tuser     out  CH_BITS          channel tag of current beat
//  - out_tvalid    out  1                to master in_tvalid
//  - out_tlast     out  1                to master in_tlast
//  - out_tready    in   1                from master in_tready
//  - grant_active  out  1                a packet is in progress
//  - grant_ch      out  CH_BITS          channel currently or last granted
// BEHAVIOUR
// Reset
//  - State=IDLE. All outputs 0. last_ch=NUM_CH-1, so the first round-robin search starts at ch 0.
// FSM (2 states)
//  - IDLE
//      - linkready=1 and any ch_tvalid: choose the first valid channel searching from last_ch+1 modulo NUM_CH.
//      - Register it into grant_ch, go to BUSY.
//      - No ch_tready is asserted in IDLE.
//      - linkready=0: stay in IDLE.
//  - BUSY
//      - ch_tready[grant_ch] = !out_tvalid | out_tready. All other ch_tready are 0.
//      - An accepted beat loads the output register: tdata, tlast, tuser=grant_ch, tvalid=1.
//      - An accepted beat with tlast: last_ch<=grant_ch, go to IDLE the next cycle.
//      - linkready dropping in BUSY does not abort; the packet completes.
// Output register
//  - out_tvalid clears on out_tready when no new beat is loaded the same cycle.
//  - Payload is stable while out_tvalid & !out_tready.
// Timing
//  - Latency ch valid -> out_tvalid is 2 cycles from IDLE (arbitrate, then load), 1 cycle within a packet.
//  - Throughput is 1 beat/clk inside a packet.
//  - There is 1 bubble cycle between packets (the IDLE arbitration cycle).
// Boundary conditions
//  - Single-beat packet (tvalid & tlast on the first beat): BUSY lasts 1 accepted beat.
//  - Granted channel drops tvalid mid-packet: stay in BUSY, hold grant, insert no beats.
//  - ch_tvalid of a non-granted channel changing while in BUSY has no effect.
//  - Reset mid-packet: drop the output register contents immediately, return to IDLE.
//      - The partial packet is lost; the master is reset from the same source.
// CONFIGURATION
//  - PONYLINK_ARB_PRIO_EN defined: in IDLE, ch 0 wins whenever valid (strict priority).
//      - The remaining channels are round-robin among themselves. last_ch is not updated by ch 0 grants.
//  - PONYLINK_ARB_PRIO_EN undefined: plain round-robin across all NUM_CH channels.
// STRUCTURE
//  - Shared package ponylink_arb_pkg: state encoding localparams ARB_IDLE=1'b0 and ARB_BUSY=1'b1.
//  - Shared package ponylink_arb_pkg: function clog2 for the CH_BITS check.
//  - One sub-module, ponylink_rr_pick: combinational rotate-priority encoder.
//      - Inputs: req[NUM_CH], last[CH_BITS].
//      - Outputs: hit, idx[CH_BITS].
//  - FSM, output register and tready gating live in the top module.
// TESTING
//  - Ch1 sends one 3-beat packet 0x11,0x12,0x13 (last), out_tready=1:
//      - out emits 0x11..0x13 with tuser=1, tlast only on 0x13.
//      - First out_tvalid is 2 cycles after ch_tvalid.
//  - Ch0..3 all valid, each sends 2-beat packets, three rounds:
//      - Grant order 0,1,2,3,0,1,2,3,0,1,2,3.
//      - No interleaving; 1 idle cycle between packets.
//  - out_tready toggles 1,0,0,1 during a 4-beat ch2 packet:
//      - out_tdata stable while stalled; all 4 beats are delivered in order, with no loss or duplication.
//  - linkready=0 with ch3 valid: no grant and ch_tready=0.
//  - linkready rises: ch3 is granted the next cycle.
//  - linkready falls mid-packet: the packet still completes.
//  - Reset asserted on beat 2 of a 5-beat packet:
//      - Next cycle out_tvalid=0, grant_active=0.
//      - After release, ch0 is granted first.
//  - With PONYLINK_ARB_PRIO_EN, ch0 and ch2 are continuously valid: ch0 gets every grant.
//  - Without the macro, same stimulus: grants alternate 0,2,0,2.

Source files
------------

// File: rtl/ponylink_arb_pkg.sv
// ponylink_arb_pkg: shared state encoding and helpers for the ponylink M2S packet arbiter
package ponylink_arb_pkg;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/ponylink_rr_pick.sv
// ponylink_rr_pick: rotate-priority encoder returning the first set req after index last, wrapping
module ponylink_rr_pick #(
   parameter int NUM_CH  = 4,
   parameter int CH_BITS = 2
)(
   input  logic [NUM_CH-1:0]  req,
   input  logic [CH_BITS-1:0] last,
   output logic               hit,
   output logic [CH_BITS-1:0] idx
);
   logic [2*NUM_CH-1:0] rot;
   int off;
   assign rot = {req, req} >> (int'(last) + 1);
   always_comb begin
      off = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? i : off;
      hit = |req;
      idx = CH_BITS'((int'(last) + 1 + off) % NUM_CH);
   end
endmodule

// File: rtl/ponylink_m2s_arbiter.sv
// ponylink_m2s_arbiter: packet-granular round-robin arbiter sharing the ponylink_master M2S stream, tagging beats with the source channel.
// Define PONYLINK_ARB_PRIO_EN to give ch 0 strict priority over the round-robin channels.
module ponylink_m2s_arbiter
   import ponylink_arb_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int TDATA_WIDTH = 8,
   parameter int CH_BITS     = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          linkready,
   input  logic [NUM_CH*TDATA_WIDTH-1:0] ch_tdata,
   input  logic [NUM_CH-1:0]             ch_tvalid,
   input  logic [NUM_CH-1:0]             ch_tlast,
   output logic [NUM_CH-1:0]             ch_tready,
   output logic [TDATA_WIDTH-1:0]        out_tdata,
   output logic [CH_BITS-1:0]            out_tuser,
   output logic                          out_tvalid,
   output logic                          out_tlast,
   input  logic                          out_tready,
   output logic                          grant_active,
   output logic [CH_BITS-1:0]            grant_ch
);
`ifdef PONYLINK_ARB_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif
   arb_state_e state, state_nxt;
   logic [CH_BITS-1:0] last_ch, pick_idx, win_idx;
   logic [NUM_CH-1:0] req;
   logic [TDATA_WIDTH-1:0] g_data;
   logic pick_hit, win_hit, grant, slot_free, take, g_valid, g_last;
   if (CH_BITS != clog2(NUM_CH)) begin : g_bad_cfg
      $error("ponylink_m2s_arbiter: CH_BITS must equal clog2(NUM_CH)");
   end
   // With priority enabled ch 0 is taken out of the rotation and wins outright
   assign req = PRIO_EN ? (ch_tvalid & ~NUM_CH'(1)) : ch_tvalid;
   ponylink_rr_pick #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_pick (
      .req  (req),
      .last (last_ch),
      .hit  (pick_hit),
      .idx  (pick_idx)
   );
   assign win_hit      = pick_hit || (PRIO_EN && ch_tvalid[0]);
   assign win_idx      = (PRIO_EN && ch_tvalid[0]) ? '0 : pick_idx;
   assign grant        = state == ARB_IDLE && linkready && win_hit;
   assign g_valid      = ch_tvalid[grant_ch];
   assign g_last       = ch_tlast[grant_ch];
   assign g_data       = ch_tdata[grant_ch*TDATA_WIDTH +: TDATA_WIDTH];
   assign slot_free    = !out_tvalid || out_tready;
   assign take         = state == ARB_BUSY && g_valid && slot_free;
   assign grant_active = state == ARB_BUSY;
   always_comb begin
      ch_tready = '0;
      ch_tready[grant_ch] = state == ARB_BUSY && slot_free;
      state_nxt = grant ? ARB_BUSY : (take && g_last) ? ARB_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_IDLE;
         grant_ch   <= '0;
         last_ch    <= CH_BITS'(NUM_CH - 1);
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tlast  <= 1'b0;
         out_tuser  <= '0;
      end else begin
         state <= state_nxt;
         if (grant) grant_ch <= win_idx;
         if (take) begin
            out_tdata  <= g_data;
            out_tlast  <= g_last;
            out_tuser  <= grant_ch;
            out_tvalid <= 1'b1;
         end else if (out_tready) begin
            out_tvalid <= 1'b0;
         end
         if (take && g_last && !(PRIO_EN && grant_ch == '0)) last_ch <= grant_ch;
      end
   end
endmodule

// File: tb/tb_ponylink_m2s_arbiter.sv
// tb_ponylink_m2s_arbiter: directed and randomized checks of the M2S arbiter against a packet-queue reference model.
module tb_ponylink_m2s_arbiter;
   localparam int N = 4, W = 8, CB = 2;
`ifdef PONYLINK_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   typedef struct {logic [W-1:0] d; logic l;} beat_t;
   typedef struct {logic [W-1:0] d; logic l; logic [CB-1:0] u;} obeat_t;

   logic clk = 1'b0, reset = 1'b1, linkready = 1'b0, out_tready = 1'b0;
   logic [N*W-1:0] ch_tdata = '0;
   logic [N-1:0] ch_tvalid = '0, ch_tlast = '0;
   logic [N-1:0] ch_tready;
   logic [W-1:0] out_tdata;
   logic [CB-1:0] out_tuser, grant_ch;
   logic out_tvalid, out_tlast, grant_active;

   always #5 clk = ~clk;

   ponylink_m2s_arbiter #(.NUM_CH(N), .TDATA_WIDTH(W), .CH_BITS(CB)) dut (
      .clk(clk), .reset(reset), .linkready(linkready),
      .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tlast(ch_tlast), .ch_tready(ch_tready),
      .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
      .out_tready(out_tready), .grant_active(grant_active), .grant_ch(grant_ch)
   );

   beat_t src[N][$];
   obeat_t exp_q[$];
   bit hold[N];
   bit rdy_q[$];
   int glog[$];
   int errors = 0, checks = 0, cyc = 0, beats_out = 0;
   int first_beat = -1, last_beat = -1, first_valid = -1;
   int vpct = 100, rdy_pct = 100, lr_pct = 100;
   bit m_busy = 1'b0;
   int m_grant = 0, m_last = N - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Reference arbitration: first valid channel after the last one served
   function automatic int rr(input logic [N-1:0] v, input int last);
      if (PRIO && v[0]) return 0;
      if (PRIO) v[0] = 1'b0;
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic bit src_pending();
      for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic add_pkt(input int ch, input int len, input logic [W-1:0] base, input bit rnd);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = rnd ? W'($urandom) : base + W'(i);
         b.l = (i == len - 1);
         src[ch].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         ch_tvalid[i] = src[i].size() > 0 && (hold[i] || $urandom_range(99) < vpct);
         ch_tdata[i*W +: W] = src[i].size() > 0 ? src[i][0].d : '0;
         ch_tlast[i] = src[i].size() > 0 && src[i][0].l;
      end
      out_tready = rdy_q.size() > 0 ? rdy_q.pop_front() : ($urandom_range(99) < rdy_pct);
      if (lr_pct < 100) linkready = $urandom_range(99) < lr_pct;
   endtask

   task automatic tick();
      logic [N-1:0] rdy_exp;
      bit mready, acc, arb;
      int newg;
      beat_t b;
      obeat_t o;
      drive();
      #1;
      mready = m_busy && (exp_q.size() == 0 || out_tready);
      rdy_exp = mready ? N'(1) << m_grant : '0;
      chk("ch_tready", 32'(ch_tready), 32'(rdy_exp));
      acc = mready && ch_tvalid[m_grant];
      arb = !m_busy && linkready && |ch_tvalid;
      newg = arb ? rr(ch_tvalid, m_last) : -1;
      if (out_tvalid === 1'b1 && out_tready) begin
         beats_out++;
         if (first_beat < 0) first_beat = cyc;
         last_beat = cyc;
      end
      if (exp_q.size() > 0 && out_tready) void'(exp_q.pop_front());
      for (int i = 0; i < N; i++) hold[i] = ch_tvalid[i] && !(acc && i == m_grant);
      if (acc) begin
         b = src[m_grant].pop_front();
         o.d = b.d;
         o.l = b.l;
         o.u = CB'(m_grant);
         exp_q.push_back(o);
         if (b.l) begin
            m_busy = 1'b0;
            if (!PRIO || m_grant != 0) m_last = m_grant;
         end
      end
      if (arb) begin
         m_busy = 1'b1;
         m_grant = newg;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("grant_active", 32'(grant_active), 32'(m_busy));
      if (arb) begin
         glog.push_back(int'(grant_ch));
         chk("grant_ch", 32'(grant_ch), 32'(newg));
      end
      if (out_tvalid === 1'b1 && first_valid < 0) first_valid = cyc;
      chk("out_tvalid", 32'(out_tvalid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         chk("out_tdata", 32'(out_tdata), 32'(exp_q[0].d));
         chk("out_tlast", 32'(out_tlast), 32'(exp_q[0].l));
         chk("out_tuser", 32'(out_tuser), 32'(exp_q[0].u));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      reset = 1'b0;
      exp_q.delete();
      m_busy = 1'b0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) begin
         hold[i] = 1'b0;
         src[i].delete();
      end
      chk("rst_out_tvalid", 32'(out_tvalid), 0);
      chk("rst_grant_active", 32'(grant_active), 0);
      chk("rst_ch_tready", 32'(ch_tready), 0);
      chk("rst_out_tdata", 32'(out_tdata), 0);
      chk("rst_out_tuser", 32'(out_tuser), 0);
      chk("rst_out_tlast", 32'(out_tlast), 0);
      chk("rst_grant_ch", 32'(grant_ch), 0);
   endtask

   task automatic drain(input string tag, input int max);
      int n;
      n = 0;
      while ((src_pending() || exp_q.size() > 0 || m_busy) && n < max) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < max), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, c0, n;
      do_reset();

      // Single 3-beat packet on ch1, latency from IDLE
      linkready = 1'b1;
      add_pkt(1, 3, 8'h11, 1'b0);
      glog.delete();
      first_valid = -1;
      c0 = cyc;
      b0 = beats_out;
      drain("drain_ch1", 50);
      chk("latency", 32'(first_valid - c0), 2);
      chk("ch1_grants", 32'(glog.size()), 1);
      chk("ch1_grant", 32'(glog[0]), 1);
      chk("ch1_beats", 32'(beats_out - b0), 3);

      // All channels busy: three rounds of 2-beat packets
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < N; c++) add_pkt(c, 2, W'(c * 16 + r * 2), 1'b0);
      glog.delete();
      first_beat = -1;
      b0 = beats_out;
      drain("drain_rr", 200);
      chk("rr_grants", 32'(glog.size()), 12);
      for (int i = 0; i < 12; i++) chk("rr_order", 32'(glog[i]), 32'(i % N));
      chk("rr_beats", 32'(beats_out - b0), 24);
      chk("rr_span", 32'(last_beat - first_beat), 34);

      // Backpressure toggling during a 4-beat ch2 packet
      for (int i = 0; i < 3; i++) begin
         rdy_q.push_back(1'b1);
         rdy_q.push_back(1'b0);
         rdy_q.push_back(1'b0);
         rdy_q.push_back(1'b1);
      end
      add_pkt(2, 4, 8'hA0, 1'b0);
      b0 = beats_out;
      drain("drain_stall", 50);
      chk("stall_beats", 32'(beats_out - b0), 4);
      rdy_q.delete();

      // linkready gating of new grants only
      linkready = 1'b0;
      add_pkt(3, 3, 8'h30, 1'b0);
      b0 = beats_out;
      repeat (3) tick();
      chk("lr0_active", 32'(grant_active), 0);
      chk("lr0_tready", 32'(ch_tready), 0);
      linkready = 1'b1;
      tick();
      chk("lr1_active", 32'(grant_active), 1);
      chk("lr1_grant", 32'(grant_ch), 3);
      tick();
      linkready = 1'b0;
      drain("drain_lr", 50);
      chk("lr_beats", 32'(beats_out - b0), 3);
      linkready = 1'b1;

      // Reset in the middle of a 5-beat packet
      add_pkt(2, 5, 8'h50, 1'b0);
      b0 = beats_out;
      n = 0;
      while (beats_out - b0 < 1 && n < 20) begin
         tick();
         n++;
      end
      chk("pre_reset_beats", 32'(beats_out - b0), 1);
      do_reset();
      add_pkt(0, 2, 8'h60, 1'b0);
      add_pkt(3, 2, 8'h70, 1'b0);
      glog.delete();
      drain("drain_post_reset", 50);
      chk("post_reset_first", 32'(glog[0]), 0);
      chk("post_reset_second", 32'(glog[1]), 3);

      // ch0 and ch2 continuously valid
      glog.delete();
      for (int k = 0; k < 4; k++) begin
         add_pkt(0, 2, W'(8'h80 + k * 2), 1'b0);
         add_pkt(2, 2, W'(8'hC0 + k * 2), 1'b0);
      end
      drain("drain_prio", 100);
      chk("prio_grants", 32'(glog.size()), 8);
      for (int i = 0; i < 8; i++)
         chk("prio_order", 32'(glog[i]), PRIO ? (i < 4 ? 0 : 2) : (i % 2 == 1 ? 2 : 0));

      // Randomized traffic: gaps, backpressure and linkready drops
      vpct = 70;
      rdy_pct = 70;
      lr_pct = 80;
      for (int c = 0; c < N; c++)
         for (int k = 0; k < 5; k++) add_pkt(c, $urandom_range(1, 5), 8'h00, 1'b1);
      drain("drain_rand", 3000);
      lr_pct = 100;
      linkready = 1'b1;
      vpct = 100;
      rdy_pct = 100;
      drain("drain_final", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
